// File: rtl/dcache_miss_handler_pkg.sv
// Shared constants and state encoding for the data-cache miss repair engine.
package dcache_miss_handler_pkg;

  localparam int DCACHE_LINE_BITS = 1024;
  localparam int DCACHE_BEAT_BITS = 32;
  localparam int DCACHE_BEATS     = DCACHE_LINE_BITS / DCACHE_BEAT_BITS;
  localparam int DCACHE_OFFSET_W  = $clog2(DCACHE_LINE_BITS / 8);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    RESOLVE
  } miss_state_t;

endpackage

// File: rtl/dcache_line_buffer.sv
// Line assembly register: one beat written per cycle, whole line always readable.
module dcache_line_buffer #(
  parameter int LINE_BITS = 1024,
  parameter int BEAT_BITS = 32,
  parameter int IDX_W     = $clog2(LINE_BITS / BEAT_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BEAT_BITS-1:0] wr_data,
  output logic [LINE_BITS-1:0] rd_line
);

  logic [LINE_BITS-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (wr_en) begin
      line_q[wr_idx*BEAT_BITS +: BEAT_BITS] <= wr_data;
    end
  end

  assign rd_line = line_q;

endmodule

// File: rtl/dcache_miss_handler.sv
// Read-miss repair: fetch a full line as pipelined beats, then fill the controller once.
module dcache_miss_handler
  import dcache_miss_handler_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int LINE_BITS       = DCACHE_LINE_BITS,
  parameter int BEAT_BITS       = DCACHE_BEAT_BITS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read_repair_request,
  input  logic [ADDR_W-1:0]      missed_addr,
  output logic                   fill_valid,
  output logic [ADDR_W-1:0]      fill_addr,
  output logic [LINE_BITS-1:0]   fill_data,
  output logic [LINE_BITS/8-1:0] fill_mask,
  output logic                   repair_resolved,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [BEAT_BITS-1:0]   mem_resp_data
);

  localparam int BEATS      = LINE_BITS / BEAT_BITS;
  localparam int BEAT_SHIFT = $clog2(BEAT_BITS / 8);
  localparam int CNT_W      = $clog2(BEATS + 1);
  localparam int IDX_W      = $clog2(BEATS);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BITS / 8 - 1);

  miss_state_t            state_q;
  logic                   req_q;
  logic [ADDR_W-1:0]      base_q;
  logic [CNT_W-1:0]       issue_q, recv_q;
  logic [OUT_W-1:0]       outst_q;
  logic                   fill_valid_q, resolved_q;
  logic [ADDR_W-1:0]      fill_addr_q;
  logic [LINE_BITS/8-1:0] fill_mask_q;

  logic req_edge, resp_acc, req_fire;

  assign req_edge = read_repair_request & ~req_q;
  // Responses only count while fetching and only up to the last beat of the line.
  assign resp_acc = (state_q == FETCH) && mem_resp_valid && (recv_q < CNT_W'(BEATS));
  // A response landing this cycle frees a slot, so issue may proceed at the limit.
  assign mem_req_valid = (state_q == FETCH) && (issue_q < CNT_W'(BEATS)) &&
                         ((outst_q < OUT_W'(MAX_OUTSTANDING)) || resp_acc);
  assign mem_req_addr  = base_q + (ADDR_W'(issue_q) << BEAT_SHIFT);
  assign req_fire      = mem_req_valid & mem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      base_q       <= '0;
      issue_q      <= '0;
      recv_q       <= '0;
      outst_q      <= '0;
      fill_valid_q <= 1'b0;
      resolved_q   <= 1'b0;
      fill_addr_q  <= '0;
      fill_mask_q  <= '0;
    end else begin
      req_q        <= read_repair_request;
      fill_valid_q <= 1'b0;
      resolved_q   <= 1'b0;
      fill_addr_q  <= '0;
      fill_mask_q  <= '0;
      case (state_q)
        IDLE: begin
          if (req_edge) begin
            base_q  <= missed_addr & ~OFF_MASK;
            issue_q <= '0;
            recv_q  <= '0;
            outst_q <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (req_fire) issue_q <= issue_q + CNT_W'(1);
          if (resp_acc) recv_q <= recv_q + CNT_W'(1);
          case ({req_fire, resp_acc})
            2'b10:   outst_q <= outst_q + OUT_W'(1);
            2'b01:   outst_q <= outst_q - OUT_W'(1);
            default: outst_q <= outst_q;
          endcase
          if (resp_acc && (recv_q == CNT_W'(BEATS - 1))) begin
            state_q      <= FILL;
            fill_valid_q <= 1'b1;
            fill_addr_q  <= base_q;
            fill_mask_q  <= '1;
          end
        end
        FILL: begin
          state_q    <= RESOLVE;
          resolved_q <= 1'b1;
        end
        RESOLVE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  dcache_line_buffer #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS),
    .IDX_W     (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (resp_acc),
    .wr_idx  (recv_q[IDX_W-1:0]),
    .wr_data (mem_resp_data),
    .rd_line (fill_data)
  );

  assign fill_valid      = fill_valid_q;
  assign fill_addr       = fill_addr_q;
  assign fill_mask       = fill_mask_q;
  assign repair_resolved = resolved_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Bench: randomized memory latency/backpressure against a line-level reference model.
module tb_dcache_miss_handler;

  localparam int LB = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            read_repair_request = 1'b0;
  logic [31:0]     missed_addr = '0;
  logic            fill_valid;
  logic [31:0]     fill_addr;
  logic [LB-1:0]   fill_data;
  logic [LB/8-1:0] fill_mask;
  logic            repair_resolved;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b1;
  logic [31:0]     mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [31:0]     mem_resp_data = '0;

  dcache_miss_handler dut (
    .clk(clk), .rst_n(rst_n), .read_repair_request(read_repair_request),
    .missed_addr(missed_addr), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_mask(fill_mask), .repair_resolved(repair_resolved),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t        mq[$];
  logic [31:0]  issued_q[$];
  int           checks = 0, failures = 0;
  int           cyc = 0, lat = 2, ready_mode = 0;
  bit           use_hash = 0, inject = 0;
  logic [31:0]  salt = 32'h0;
  int           fill_cnt, fill_cyc, res_cnt, res_cyc, first_req_cyc, resp_cnt;
  int           max_outst, stall_viol;
  bit           prev_stall = 0;
  logic [31:0]  prev_addr, fill_addr_s;
  logic [LB/8-1:0] fill_mask_s;
  logic [LB-1:0]   fill_data_s, last_exp;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (use_hash) return salt ^ (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    return 32'h1000_0000 + ((a >> 2) & 32'h1F);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'h7F;
  endfunction

  function automatic logic [LB-1:0] exp_line(input logic [31:0] base);
    logic [LB-1:0] l;
    for (int i = 0; i < 32; i++) l[i*32 +: 32] = mem_data(base + 32'(i * 4));
    return l;
  endfunction

  function automatic int first_diff(input logic [LB-1:0] a, input logic [LB-1:0] b);
    for (int i = 0; i < 32; i++) if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return 0;
  endfunction

  function automatic int addr_errs(input logic [31:0] base);
    int bad = 0;
    if (issued_q.size() != 32) return 99;
    for (int i = 0; i < 32; i++) if (issued_q[i] !== base + 32'(i * 4)) bad++;
    return bad;
  endfunction

  task automatic clear_obs();
    issued_q.delete();
    fill_cnt = 0; res_cnt = 0; fill_cyc = -1; res_cyc = -1; first_req_cyc = -1;
    resp_cnt = 0; max_outst = 0; stall_viol = 0;
  endtask

  // One clock: observe at negedge, then act as the memory just after posedge.
  task automatic cycle();
    bit hs; logic [31:0] hs_addr; int hs_cyc;
    @(negedge clk);
    hs = mem_req_valid & mem_req_ready; hs_addr = mem_req_addr; hs_cyc = cyc;
    if (mem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
    if (prev_stall && (!mem_req_valid || mem_req_addr !== prev_addr)) stall_viol++;
    prev_stall = mem_req_valid & ~mem_req_ready; prev_addr = mem_req_addr;
    if (mq.size() + int'(hs) > max_outst) max_outst = mq.size() + int'(hs);
    if (fill_valid) begin
      fill_cnt++; fill_cyc = cyc; fill_addr_s = fill_addr;
      fill_mask_s = fill_mask; fill_data_s = fill_data;
    end
    if (repair_resolved) begin res_cnt++; res_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
    if (hs) begin issued_q.push_back(hs_addr); mq.push_back('{hs_addr, hs_cyc + lat}); end
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_resp_valid = 1'b1; mem_resp_data = mem_data(mq[0].addr);
      void'(mq.pop_front()); resp_cnt++;
    end else if (inject) begin
      mem_resp_valid = 1'b1; mem_resp_data = $urandom; inject = 0;
    end
    case (ready_mode)
      1:       mem_req_ready = ~mem_req_ready;
      2:       mem_req_ready = ($urandom_range(0, 3) != 0);
      default: mem_req_ready = 1'b1;
    endcase
  endtask

  task automatic run_until_resolved(input int maxc, output bit timed_out);
    int r0 = res_cnt;
    timed_out = 1;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (res_cnt != r0) begin timed_out = 0; break; end
    end
  endtask

  task automatic start_miss(input logic [31:0] a, output int t0);
    read_repair_request = 1'b1; missed_addr = a; t0 = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_obs();
    repeat (3) cycle();
    checks++; if ({fill_valid, repair_resolved, mem_req_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes: got %b expected 000", {fill_valid, repair_resolved, mem_req_valid}); end
    checks++; if (fill_data !== '0 || fill_addr !== '0 || fill_mask !== '0 || mem_req_addr !== '0) begin
      failures++; $display("FAIL reset_data: got addr %h mask_nz %0d data_nz %0d expected all zero", fill_addr, fill_mask != '0, fill_data != '0); end
    rst_n = 1'b1;
    repeat (3) cycle();
    checks++; if (mem_req_valid !== 1'b0 || fill_cnt != 0) begin
      failures++; $display("FAIL reset_idle: got req_valid %b fills %0d expected 0 0", mem_req_valid, fill_cnt); end
  endtask

  task automatic test_basic();
    int t0; bit to; logic [LB-1:0] e;
    clear_obs(); lat = 2; ready_mode = 0; use_hash = 0; mem_req_ready = 1'b1;
    start_miss(32'hAABB_CCDD, t0);
    run_until_resolved(200, to);
    read_repair_request = 1'b0; cycle();
    e = exp_line(32'hAABB_CC80); last_exp = e;
    checks++; if (to) begin failures++; $display("FAIL basic_timeout: got no resolve expected resolve"); end
    checks++; if (first_req_cyc != t0 + 1) begin
      failures++; $display("FAIL basic_first_req: got cycle %0d expected %0d", first_req_cyc - t0, 1); end
    checks++; if (addr_errs(32'hAABB_CC80) != 0) begin
      failures++; $display("FAIL basic_addrs: got %0d bad (n=%0d) expected 0", addr_errs(32'hAABB_CC80), issued_q.size()); end
    checks++; if (fill_addr_s !== 32'hAABB_CC80 || fill_mask_s !== '1) begin
      failures++; $display("FAIL basic_fill_addr_mask: got %h allones=%0d expected aabbcc80 1", fill_addr_s, fill_mask_s === '1); end
    checks++; if (fill_data_s[31:0] !== 32'h1000_0000 || fill_data_s[1023:992] !== 32'h1000_001F) begin
      failures++; $display("FAIL basic_ends: got %h %h expected 10000000 1000001f", fill_data_s[31:0], fill_data_s[1023:992]); end
    checks++; if (fill_data_s !== e) begin
      failures++; $display("FAIL basic_line: beat %0d got %h expected %h", first_diff(fill_data_s, e), fill_data_s[first_diff(fill_data_s, e)*32 +: 32], e[first_diff(fill_data_s, e)*32 +: 32]); end
    checks++; if (fill_cyc != t0 + 35 || res_cyc != t0 + 36) begin
      failures++; $display("FAIL basic_timing: got fill %0d resolve %0d expected 35 36", fill_cyc - t0, res_cyc - t0); end
    checks++; if (fill_cnt != 1 || res_cnt != 1) begin
      failures++; $display("FAIL basic_counts: got %0d fills %0d resolves expected 1 1", fill_cnt, res_cnt); end
  endtask

  task automatic test_backpressure(input string nm, input int l, input int mode, input bit want_full);
    int t0; bit to; logic [31:0] a, b; logic [LB-1:0] e;
    clear_obs(); lat = l; ready_mode = mode; use_hash = 1; salt = $urandom;
    a = $urandom; b = line_base(a);
    start_miss(a, t0);
    run_until_resolved(1500, to);
    read_repair_request = 1'b0; cycle();
    e = exp_line(b); last_exp = e;
    checks++; if (to) begin failures++; $display("FAIL %s_timeout: got no resolve expected resolve", nm); end
    checks++; if (max_outst > 4 || (want_full && max_outst != 4)) begin
      failures++; $display("FAIL %s_outstanding: got max %0d expected %s", nm, max_outst, want_full ? "4" : "<=4"); end
    checks++; if (stall_viol != 0) begin
      failures++; $display("FAIL %s_stall_stable: got %0d changes expected 0", nm, stall_viol); end
    checks++; if (addr_errs(b) != 0 || fill_addr_s !== b) begin
      failures++; $display("FAIL %s_addrs: got %0d bad fill_addr %h expected 0 %h", nm, addr_errs(b), fill_addr_s, b); end
    checks++; if (fill_data_s !== e) begin
      failures++; $display("FAIL %s_line: beat %0d got %h expected %h", nm, first_diff(fill_data_s, e), fill_data_s[first_diff(fill_data_s, e)*32 +: 32], e[first_diff(fill_data_s, e)*32 +: 32]); end
    ready_mode = 0;
  endtask

  task automatic test_held();
    int t0; bit to;
    clear_obs(); lat = 3; ready_mode = 0; use_hash = 1; salt = $urandom;
    start_miss($urandom, t0);
    run_until_resolved(300, to);
    repeat (5) cycle();
    checks++; if (to || fill_cnt != 1 || res_cnt != 1) begin
      failures++; $display("FAIL held_once: got fills %0d resolves %0d timeout %0d expected 1 1 0", fill_cnt, res_cnt, to); end
    checks++; if (issued_q.size() != 32 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL held_no_refetch: got %0d requests valid %b expected 32 0", issued_q.size(), mem_req_valid); end
    last_exp = exp_line(line_base(missed_addr));
    read_repair_request = 1'b0; cycle();
  endtask

  task automatic test_spurious();
    int t0; bit to; logic [31:0] a, b; logic [LB-1:0] e;
    clear_obs(); lat = 2; ready_mode = 0;
    inject = 1; repeat (3) cycle();
    checks++; if (fill_data !== last_exp) begin
      failures++; $display("FAIL spur_idle_resp: beat %0d got %h expected %h", first_diff(fill_data, last_exp), fill_data[first_diff(fill_data, last_exp)*32 +: 32], last_exp[first_diff(fill_data, last_exp)*32 +: 32]); end
    salt = $urandom; a = $urandom; b = line_base(a);
    start_miss(a, t0);
    repeat (6) cycle();
    read_repair_request = 1'b0; cycle();
    read_repair_request = 1'b1; missed_addr = a ^ 32'h5555_0000;
    run_until_resolved(300, to);
    read_repair_request = 1'b0; cycle();
    e = exp_line(b); last_exp = e;
    checks++; if (to || fill_cnt != 1 || fill_addr_s !== b || addr_errs(b) != 0) begin
      failures++; $display("FAIL spur_edge_in_fetch: got fills %0d addr %h bad %0d expected 1 %h 0", fill_cnt, fill_addr_s, addr_errs(b), b); end
    checks++; if (fill_data_s !== e) begin
      failures++; $display("FAIL spur_line: beat %0d got %h expected %h", first_diff(fill_data_s, e), fill_data_s[first_diff(fill_data_s, e)*32 +: 32], e[first_diff(fill_data_s, e)*32 +: 32]); end
  endtask

  task automatic test_reset_mid();
    int t0, n; bit to; logic [LB-1:0] e;
    clear_obs(); lat = 2; ready_mode = 0; salt = $urandom;
    start_miss($urandom, t0);
    n = 0;
    while (resp_cnt < 10 && n < 100) begin cycle(); n++; end
    cycle();
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({fill_valid, repair_resolved, mem_req_valid} !== 3'b000 || mem_req_addr !== '0 ||
                  fill_addr !== '0 || fill_mask !== '0 || fill_data !== '0 || n >= 100) begin
      failures++; $display("FAIL reset_async: got v%b r%b q%b qa %h fa %h data_nz %0d expected all zero",
                           fill_valid, repair_resolved, mem_req_valid, mem_req_addr, fill_addr, fill_data != '0); end
    mq.delete(); mem_resp_valid = 1'b0; read_repair_request = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1; cycle();
    clear_obs();
    start_miss(32'h0000_0100, t0);
    run_until_resolved(300, to);
    read_repair_request = 1'b0; cycle();
    e = exp_line(32'h0000_0100); last_exp = e;
    checks++; if (to || issued_q.size() == 0 || issued_q[0] !== 32'h0000_0100 || addr_errs(32'h100) != 0) begin
      failures++; $display("FAIL reset_refetch_addr: got first %h bad %0d expected 00000100 0", issued_q.size() ? issued_q[0] : 32'hx, addr_errs(32'h100)); end
    checks++; if (fill_data_s !== e || fill_addr_s !== 32'h100) begin
      failures++; $display("FAIL reset_refetch_line: beat %0d got %h expected %h", first_diff(fill_data_s, e), fill_data_s[first_diff(fill_data_s, e)*32 +: 32], e[first_diff(fill_data_s, e)*32 +: 32]); end
  endtask

  task automatic test_back_to_back();
    int t0, n, r1; bit to; logic [31:0] a, b; logic [LB-1:0] e1, e2;
    clear_obs(); lat = 3; ready_mode = 0; salt = $urandom;
    a = $urandom; b = $urandom;
    start_miss(a, t0);
    n = 0;
    while (fill_cnt == 0 && n < 300) begin cycle(); n++; end
    e1 = exp_line(line_base(a));
    checks++; if (fill_data_s !== e1 || fill_addr_s !== line_base(a) || addr_errs(line_base(a)) != 0) begin
      failures++; $display("FAIL b2b_first: beat %0d got %h expected %h", first_diff(fill_data_s, e1), fill_data_s[first_diff(fill_data_s, e1)*32 +: 32], e1[first_diff(fill_data_s, e1)*32 +: 32]); end
    read_repair_request = 1'b0; cycle();
    r1 = res_cyc;
    issued_q.delete(); first_req_cyc = -1;
    start_miss(b, t0);
    run_until_resolved(300, to);
    read_repair_request = 1'b0; cycle();
    e2 = exp_line(line_base(b)); last_exp = e2;
    checks++; if (to || r1 < 0 || first_req_cyc != r1 + 2) begin
      failures++; $display("FAIL b2b_restart: got first req %0d cycles after resolve expected 2", first_req_cyc - r1); end
    checks++; if (fill_cnt != 2 || fill_data_s !== e2 || fill_addr_s !== line_base(b) || addr_errs(line_base(b)) != 0) begin
      failures++; $display("FAIL b2b_second: fills %0d addr %h got beat %h expected addr %h beat %h", fill_cnt, fill_addr_s, fill_data_s[first_diff(fill_data_s, e2)*32 +: 32], line_base(b), e2[first_diff(fill_data_s, e2)*32 +: 32]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure("bp", 6, 1, 1'b0);
    test_backpressure("limit", 7, 0, 1'b1);
    for (int k = 0; k < 3; k++) test_backpressure("rand", $urandom_range(1, 9), 2, 1'b0);
    test_held();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
